// File: rtl/mem8_resp.sv
// Byte-wide memory responder with a 4-phase req/ack handshake and WAIT_CYC wait states.
// Optional transfer counters (rd_cnt/wr_cnt) are built only when MEM8_RESP_STATS_EN is defined.
module mem8_resp #(
    parameter int AW       = 4,
    parameter int WAIT_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic          ack,
    output logic [7:0]    rdata,
    output logic          busy
`ifdef MEM8_RESP_STATS_EN
    ,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int         WAIT_M1    = (WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0;
    localparam logic [3:0] CNT_INIT   = 4'(WAIT_M1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          lat_we_q, lat_we_d;
    logic [AW-1:0] lat_addr_q, lat_addr_d;
    logic [7:0]    lat_wdata_q, lat_wdata_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          access_s, rd_s, wr_s;

    logic [7:0]    mem_q [0:(2**AW)-1];

    // Next-state, wait counter and request latching.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    lat_we_d    = we;
                    lat_addr_d  = addr;
                    lat_wdata_d = wdata;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_ACK;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (req) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The access fires on the edge that enters ACK; reset asserted at that edge suppresses it.
    always_comb begin
        access_s = (state_d == ST_ACK) && (state_q != ST_ACK) && !rst;
        rd_s     = access_s && !lat_we_d;
        wr_s     = access_s && lat_we_d;
        if (rd_s) begin
            rdata_d = mem_q[lat_addr_d];
        end else begin
            rdata_d = rdata_q;
        end
        ack_d  = (state_d == ST_ACK);
        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= 8'd0;
            rdata_q     <= 8'd0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
        end
    end

    // Storage array; deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[lat_addr_d] <= lat_wdata_d;
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;

`ifdef MEM8_RESP_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    // Completed-transfer counters, wrapping at 16 bits.
    always_comb begin
        rd_cnt_d = rd_cnt_q + {15'd0, rd_s};
        wr_cnt_d = wr_cnt_q + {15'd0, wr_s};
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem8_resp.sv
// Self-checking bench for mem8_resp: table vectors, corner sequences and random traffic
// against a reference memory model; one instance at WAIT_CYC=2 and one at WAIT_CYC=0.
`timescale 1ns/100ps
module tb_mem8_resp;

    localparam int AW = 4;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we, req0, we0;
    logic [AW-1:0] addr, addr0;
    logic [7:0]    wdata, wdata0;
    logic          ack, busy, ack0, busy0;
    logic [7:0]    rdata, rdata0;
`ifdef MEM8_RESP_STATS_EN
    logic [15:0]   rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] ref_mem [0:15];
    logic [7:0] ref_rdata;
    int         ref_rd, ref_wr;

    typedef struct {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    mem8_resp #(.AW(AW), .WAIT_CYC(WC)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .busy(busy)
`ifdef MEM8_RESP_STATS_EN
        , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
    );

    mem8_resp #(.AW(AW), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .busy(busy0)
`ifdef MEM8_RESP_STATS_EN
        , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ref_rdata = 8'h00;
        ref_rd    = 0;
        ref_wr    = 0;
    endtask

    // One full handshake on the WAIT_CYC=2 instance; called and returns at a falling edge.
    task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d,
                        input bit scramble, input bit drop_early);
        int first_ack = -1;
        int n_ack     = 0;
        bit busy_hi   = 1'b1;
        req = 1'b1; we = w; addr = a; wdata = d;
        for (int k = 1; k <= WC + 6; k++) begin
            @(negedge clk);
            if (ack) begin
                n_ack++;
                if (first_ack < 0) first_ack = k;
            end
            if (k <= WC + 1 && !busy) busy_hi = 1'b0;
            if (k == 1 && scramble) begin
                addr = ~a; wdata = ~d; we = ~w;
            end
            if (k == 1 && drop_early) req = 1'b0;
            if (first_ack == k) req = 1'b0;
        end
        req = 1'b0;
        if (w) begin
            ref_mem[a] = d;
            ref_wr++;
        end else begin
            ref_rdata = ref_mem[a];
            ref_rd++;
        end
        check("ack_latency", first_ack, WC + 1);
        check("ack_pulses", n_ack, 1);
        check("busy_during", {31'd0, busy_hi}, 1);
        check("busy_after", {31'd0, busy}, 0);
        check("rdata", {24'd0, rdata}, {24'd0, ref_rdata});
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = 8'h00;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = 8'h00;
        model_reset();

        tbl[0] = '{1'b1, 4'd3,  8'hA5, 8'h00};
        tbl[1] = '{1'b0, 4'd3,  8'h00, 8'hA5};
        tbl[2] = '{1'b1, 4'd0,  8'h5A, 8'hA5};
        tbl[3] = '{1'b1, 4'd15, 8'hFF, 8'hA5};
        tbl[4] = '{1'b0, 4'd15, 8'h00, 8'hFF};
        tbl[5] = '{1'b0, 4'd0,  8'h00, 8'h5A};
        tbl[6] = '{1'b1, 4'd3,  8'hC3, 8'h5A};
        tbl[7] = '{1'b0, 4'd3,  8'h00, 8'hC3};

        #1;
        check("rst_ack", {31'd0, ack}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_rdata", {24'd0, rdata}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill every location so later reads have defined expectations.
        for (int i = 0; i < 16; i++) xfer(1'b1, 4'(i), 8'(i * 17 + 3), 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            xfer(tbl[i].w, tbl[i].a, tbl[i].d, 1'b0, 1'b0);
            check("tbl_rdata", {24'd0, rdata}, {24'd0, tbl[i].exp});
        end

        // Clockless reset pulse in the middle of a read.
        req = 1'b1; we = 1'b0; addr = 4'd3;
        @(negedge clk);
        check("pulse_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        check("pulse_ack", {31'd0, ack}, 0);
        check("pulse_busy", {31'd0, busy}, 0);
        check("pulse_rdata", {24'd0, rdata}, 0);
        rst = 1'b0; req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("pulse_idle", {31'd0, busy}, 0);
        xfer(1'b0, 4'd3, 8'h00, 1'b0, 1'b0);

        // Abort a write during WAIT; memory must keep the old byte.
        xfer(1'b1, 4'd7, 8'h11, 1'b0, 1'b0);
        req = 1'b1; we = 1'b1; addr = 4'd7; wdata = 8'h3C;
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        rst = 1'b0;
        model_reset();
        xfer(1'b0, 4'd7, 8'h00, 1'b0, 1'b0);
        check("abort_keep", {24'd0, rdata}, 32'h11);

        // Inputs changing during WAIT and req dropping early.
        xfer(1'b1, 4'd9, 8'h77, 1'b1, 1'b0);
        xfer(1'b0, 4'd9, 8'h00, 1'b1, 1'b0);
        check("stable_rd9", {24'd0, rdata}, 32'h77);
        xfer(1'b0, 4'd6, 8'h00, 1'b0, 1'b1);
        xfer(1'b1, 4'd12, 8'hE1, 1'b1, 1'b1);
        xfer(1'b0, 4'd12, 8'h00, 1'b0, 1'b0);
        check("early_drop_rd", {24'd0, rdata}, 32'hE1);

        // Zero-wait instance: write, then a read with req held for several cycles.
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd1; wdata0 = 8'h42;
        @(negedge clk);
        check("zw_wr_ack", {31'd0, ack0}, 1);
        req0 = 1'b0;
        @(negedge clk);
        check("zw_wr_ackfall", {31'd0, ack0}, 0);
        @(negedge clk);
        check("zw_wr_idle", {31'd0, busy0}, 0);
        begin
            int zw_acks   = 0;
            int zw_first  = -1;
            bit zw_busy   = 1'b1;
            req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1; wdata0 = 8'h00;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (ack0) begin
                    zw_acks++;
                    if (zw_first < 0) zw_first = k;
                end
                if (!busy0) zw_busy = 1'b0;
            end
            req0 = 1'b0;
            check("zw_rd_first", zw_first, 1);
            check("zw_rd_acks", zw_acks, 1);
            check("zw_rd_busy", {31'd0, zw_busy}, 1);
            check("zw_rd_data", {24'd0, rdata0}, 32'h42);
            @(negedge clk);
            check("zw_rd_idle", {31'd0, busy0}, 0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            xfer(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef MEM8_RESP_STATS_EN
        check("stats_wr_model", {16'd0, wr_cnt}, ref_wr);
        check("stats_rd_model", {16'd0, rd_cnt}, ref_rd);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) xfer(1'b1, 4'(i + 4), 8'(i + 1), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) xfer(1'b0, 4'(i + 4), 8'h00, 1'b0, 1'b0);
        check("stats_wr", {16'd0, wr_cnt}, 3);
        check("stats_rd", {16'd0, rd_cnt}, 2);
        rst = 1'b1;
        #1;
        check("stats_wr_rst", {16'd0, wr_cnt}, 0);
        check("stats_rd_rst", {16'd0, rd_cnt}, 0);
        rst = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
